// File: rtl/pcie_csr_scratch_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_csr_bank_pkg
// Brief    : Shared map offsets, request struct and response FSM states for
//            the PCIe CSR scratch bank.
// Revision : 1.0 - initial release
// ============================================================================
package pcie_csr_bank_pkg;

    localparam logic [63:0] DFH_OFF             = 64'h0;
    localparam logic [63:0] SCRATCH_BASE        = 64'h8;
    localparam int          STATUS_BIT_UNMAPPED = 0;
    localparam int          STATUS_BIT_MISALIGN = 1;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } t_csr_req;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } t_rsp_state;

    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_val;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_csr_scratch_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : pcie_csr_scratch_bank_if
// Brief    : Request/response bus between the CSR decoder and the scratch bank.
// Revision : 1.0 - initial release
// ============================================================================
interface pcie_csr_scratch_bank_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [7:0]        req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/pcie_csr_strb_reg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_csr_strb_reg
// Brief    : One 64-bit byte-strobed register with a parameterised reset value.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_csr_strb_reg
    import pcie_csr_bank_pkg::*;
#(
    parameter logic [63:0] RST_VAL = 64'h0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        we,
    input  wire logic [63:0] wdata,
    input  wire logic [7:0]  wstrb,
    output logic      [63:0] q
);
    logic [63:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (we) begin
            r_q <= strb_merge(r_q, wdata, wstrb);
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/pcie_csr_scratch_bank.sv
`default_nettype none
// ============================================================================
// Module   : pcie_csr_scratch_bank
// Brief    : MMIO CSR bank: DFH, scratchpads, testpad and sticky status, with a
//            one-deep read response. Optional PCIE_CSR_BANK_WR_CNT_EN adds a
//            saturating write counter at TESTPAD_OFF+0x10.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_csr_scratch_bank
    import pcie_csr_bank_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int          NUM_SCRATCH = 1,
    parameter logic [15:0] TESTPAD_OFF = 16'h28,
    parameter logic [63:0] DFH_VALUE   = 64'h3000_0000_1000_0010,
    parameter logic [63:0] SCRATCH_RST = 64'h0
) (
    input wire logic               clk,
    input wire logic               rst_n,
    pcie_csr_scratch_bank_if.slave bus
);
    localparam logic [63:0] c_testpad_off = 64'(TESTPAD_OFF);
    localparam logic [63:0] c_status_off  = c_testpad_off + 64'h8;

    t_csr_req         w_req;
    t_rsp_state       r_state;
    t_rsp_state       w_state_nxt;
    logic             w_accept;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_dfh_hit;
    logic             w_testpad_hit;
    logic             w_status_hit;
    logic             w_mapped;
    logic             w_misalign;
    logic [NUM_SCRATCH-1:0] w_scratch_hit;
    logic [63:0]      w_scratch_q [NUM_SCRATCH];
    logic [63:0]      w_testpad_q;
    logic [1:0]       r_status;
    logic [1:0]       w_status_set;
    logic [1:0]       w_status_clr;
    logic [63:0]      w_rd_data;
    logic             w_rd_err;
    logic [63:0]      r_rsp_data;
    logic             r_rsp_err;

    assign w_req.write = bus.req_write;
    assign w_req.addr  = 64'(bus.req_addr[ADDR_W-1:0]);
    assign w_req.wdata = bus.req_wdata;
    assign w_req.wstrb = bus.req_wstrb;

    assign bus.req_ready = (r_state == IDLE) | bus.rsp_ready;
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_wr_acc      = w_accept & w_req.write;
    assign w_rd_acc      = w_accept & ~w_req.write;

    // Exact full-address compares: a misaligned offset can never hit.
    assign w_misalign    = |w_req.addr[2:0];
    assign w_dfh_hit     = (w_req.addr == DFH_OFF);
    assign w_testpad_hit = (w_req.addr == c_testpad_off);
    assign w_status_hit  = (w_req.addr == c_status_off);

    generate
        for (genvar i = 0; i < NUM_SCRATCH; i++) begin : g_scratch
            localparam logic [63:0] c_off = SCRATCH_BASE + 64'(8 * i);
            assign w_scratch_hit[i] = (w_req.addr == c_off);
            pcie_csr_strb_reg #(.RST_VAL(SCRATCH_RST)) u_scratch (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (w_wr_acc & w_scratch_hit[i]),
                .wdata (w_req.wdata),
                .wstrb (w_req.wstrb),
                .q     (w_scratch_q[i])
            );
        end
    endgenerate

    pcie_csr_strb_reg #(.RST_VAL(SCRATCH_RST)) u_testpad (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr_acc & w_testpad_hit),
        .wdata (w_req.wdata),
        .wstrb (w_req.wstrb),
        .q     (w_testpad_q)
    );

`ifdef PCIE_CSR_BANK_WR_CNT_EN
    localparam logic [63:0] c_wr_cnt_off = c_testpad_off + 64'h10;
    logic        w_cnt_hit;
    logic [31:0] r_wr_cnt;

    assign w_cnt_hit = (w_req.addr == c_wr_cnt_off);
    assign w_mapped  = w_dfh_hit | (|w_scratch_hit) | w_testpad_hit | w_status_hit | w_cnt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= 32'h0;
        end else if (w_wr_acc && w_mapped && (|w_req.wstrb) && (r_wr_cnt != 32'hFFFF_FFFF)) begin
            r_wr_cnt <= r_wr_cnt + 32'h1;
        end
    end
`else
    assign w_mapped = w_dfh_hit | (|w_scratch_hit) | w_testpad_hit | w_status_hit;
`endif

    // Clear then set, so an error arriving with a W1C still lands.
    always_comb begin
        w_status_set = 2'b00;
        w_status_clr = 2'b00;
        if (w_accept && !w_mapped) begin
            w_status_set[STATUS_BIT_UNMAPPED] = 1'b1;
            w_status_set[STATUS_BIT_MISALIGN] = w_misalign;
        end
        if (w_wr_acc && w_status_hit && w_req.wstrb[0]) begin
            w_status_clr = w_req.wdata[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 2'b00;
        end else begin
            r_status <= (r_status & ~w_status_clr) | w_status_set;
        end
    end

    always_comb begin
        w_rd_data = 64'h0;
        w_rd_err  = ~w_mapped;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (w_scratch_hit[i]) w_rd_data = w_scratch_q[i];
        end
        if (w_dfh_hit)     w_rd_data = DFH_VALUE;
        if (w_testpad_hit) w_rd_data = w_testpad_q;
        if (w_status_hit)  w_rd_data = {62'h0, r_status};
`ifdef PCIE_CSR_BANK_WR_CNT_EN
        if (w_cnt_hit)     w_rd_data = {32'h0, r_wr_cnt};
`endif
    end

    // Only loaded on acceptance, which cannot happen while a response is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= 64'h0;
            r_rsp_err  <= 1'b0;
        end else if (w_rd_acc) begin
            r_rsp_data <= w_rd_data;
            r_rsp_err  <= w_rd_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rd_acc) w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready && !w_rd_acc) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_pcie_csr_scratch_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_csr_scratch_bank
// Brief    : Scoreboard bench for pcie_csr_scratch_bank (NUM_SCRATCH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_csr_scratch_bank;
    localparam logic [63:0] c_dfh = 64'h3000_0000_1000_0010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcie_csr_scratch_bank_if #(.ADDR_W(16)) bus ();

    pcie_csr_scratch_bank #(
        .ADDR_W      (16),
        .NUM_SCRATCH (4),
        .TESTPAD_OFF (16'h28),
        .DFH_VALUE   (c_dfh),
        .SCRATCH_RST (64'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          exp_wr_cnt = 0;
    logic [64:0] exp_q [$];
    logic [64:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Checks the response that retires at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got data %h with no response expected", bus.rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_data", bus.rsp_data, mon_e[63:0]);
                check("rsp_err", 64'(bus.rsp_err), 64'(mon_e[64]));
            end
        end
    end

    task automatic issue(input logic wr, input logic [15:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL req_timeout: req_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [63:0] data,
                      input logic [7:0] strb, input logic mapped);
        if (mapped && strb != 8'h0) exp_wr_cnt++;
        issue(1'b1, addr, data, strb);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [63:0] data, input logic err);
        exp_q.push_back({err, data});
        issue(1'b0, addr, 64'h0, 8'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 64'h0;
        bus.req_wstrb = 8'h0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'h1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_rsp_data", bus.rsp_data, 64'h0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'h0);

        // Reset contents of the whole map
        rd(16'h00, c_dfh, 1'b0);
        rd(16'h08, 64'h0, 1'b0);
        rd(16'h10, 64'h0, 1'b0);
        rd(16'h18, 64'h0, 1'b0);
        rd(16'h20, 64'h0, 1'b0);
        rd(16'h28, 64'h0, 1'b0);
        rd(16'h30, 64'h0, 1'b0);

        // Partial strobe, read-after-write, zero strobe
        wr(16'h08, 64'hDEAD_BEEF_0123_4567, 8'h0F, 1'b1);
        rd(16'h08, 64'h0000_0000_0123_4567, 1'b0);
        wr(16'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1);
        rd(16'h08, 64'h0000_0000_0123_4567, 1'b0);

        // Top scratchpad, neighbours untouched, DFH read-only
        wr(16'h20, 64'hA5, 8'hFF, 1'b1);
        rd(16'h20, 64'hA5, 1'b0);
        rd(16'h10, 64'h0, 1'b0);
        rd(16'h18, 64'h0, 1'b0);
        wr(16'h00, 64'h0, 8'hFF, 1'b1);
        rd(16'h00, c_dfh, 1'b0);
        rd(16'h30, 64'h0, 1'b0);

        // Unmapped read, W1C
        rd(16'h1000, 64'h0, 1'b1);
        rd(16'h30, 64'h1, 1'b0);
        wr(16'h30, 64'h1, 8'h01, 1'b1);
        rd(16'h30, 64'h0, 1'b0);

        // Misaligned read sets both bits
        rd(16'h0C, 64'h0, 1'b1);
        rd(16'h30, 64'h3, 1'b0);
        wr(16'h30, 64'h3, 8'h01, 1'b1);
        rd(16'h30, 64'h0, 1'b0);

        // Unmapped write ignored but flagged
        wr(16'h40, 64'hFF, 8'hFF, 1'b0);
        rd(16'h30, 64'h1, 1'b0);
        rd(16'h40, 64'h0, 1'b1);
        wr(16'h30, 64'h1, 8'h01, 1'b1);
        rd(16'h30, 64'h0, 1'b0);

`ifdef PCIE_CSR_BANK_WR_CNT_EN
        rd(16'h38, 64'(exp_wr_cnt), 1'b0);
`else
        rd(16'h38, 64'h0, 1'b1);
        wr(16'h30, 64'h1, 8'h01, 1'b1);
`endif

        // Testpad with upper-half strobes
        wr(16'h28, 64'h0123_4567_89AB_CDEF, 8'hF0, 1'b1);
        rd(16'h28, 64'h0123_4567_0000_0000, 1'b0);
        rd(16'h30, 64'h0, 1'b0);

        // Backpressure then back-to-back accept on release
        drain();
        bus.rsp_ready = 1'b0;
        rd(16'h20, 64'hA5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'h1);
            check("bp_req_ready", 64'(bus.req_ready), 64'h0);
            check("bp_rsp_data", bus.rsp_data, 64'hA5);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 64'h0000_0000_0123_4567});
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h08;
        @(negedge clk);
        check("b2b_req_ready", 64'(bus.req_ready), 64'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        drain();

        // Reset with a response pending
        bus.rsp_ready = 1'b0;
        issue(1'b0, 16'h20, 64'h0, 8'h0);
        @(negedge clk);
        check("pre_rst_valid", 64'(bus.rsp_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.rsp_valid), 64'h0);
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'h1);
        check("mid_rst_data", bus.rsp_data, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        exp_wr_cnt = 0;
        @(posedge clk);
        #1;
        rd(16'h20, 64'h0, 1'b0);
        rd(16'h08, 64'h0, 1'b0);
        rd(16'h28, 64'h0, 1'b0);
        rd(16'h30, 64'h0, 1'b0);
`ifdef PCIE_CSR_BANK_WR_CNT_EN
        wr(16'h08, 64'h1, 8'h01, 1'b1);
        wr(16'h10, 64'h2, 8'h01, 1'b1);
        wr(16'h50, 64'h3, 8'h01, 1'b0);
        wr(16'h18, 64'h4, 8'h01, 1'b1);
        rd(16'h38, 64'h3, 1'b0);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
